// File: rtl/ray_dispatch_pkg.sv
// Shared types and render constants for the primary-ray dispatcher.
// Optional 8x8 tile scan order is enabled with RAY_DISPATCH_TILE_EN.
package ray_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    DONE
  } RayDispatchState;

  localparam int DEFAULT_SCREEN_WIDTH  = 320;
  localparam int DEFAULT_SCREEN_HEIGHT = 240;
  localparam int DEFAULT_X_WIDTH       = 10;
  localparam int DEFAULT_Y_WIDTH       = 9;

  function automatic logic [31:0] frame_total(input int w, input int h);
    return 32'(w * h);
  endfunction

endpackage

// File: rtl/ray_dispatch_scan.sv
// pixel_scan_counter: walks every screen pixel once, raster order by default
// or 8x8 tiles when RAY_DISPATCH_TILE_EN is defined. Holds at the last pixel.
module pixel_scan_counter
  import ray_dispatch_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int X_WIDTH       = DEFAULT_X_WIDTH,
  parameter int Y_WIDTH       = DEFAULT_Y_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               step,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               last
);

  assign last = (pixel_x == X_WIDTH'(SCREEN_WIDTH - 1)) &&
                (pixel_y == Y_WIDTH'(SCREEN_HEIGHT - 1));

`ifdef RAY_DISPATCH_TILE_EN
  localparam int BX_W    = X_WIDTH - 3;
  localparam int BY_W    = Y_WIDTH - 3;
  localparam int TILES_X = SCREEN_WIDTH / 8;

  if ((SCREEN_WIDTH % 8) != 0 || (SCREEN_HEIGHT % 8) != 0) begin : g_tile_size_check
    $error("pixel_scan_counter: tile scan needs screen dimensions that are multiples of 8");
  end

  logic [2:0]      tx;
  logic [2:0]      ty;
  logic [BX_W-1:0] bx;
  logic [BY_W-1:0] by;

  // Local pixel advances fastest, then row within tile, then tile column, then tile row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx <= '0;
      ty <= '0;
      bx <= '0;
      by <= '0;
    end else if (clear) begin
      tx <= '0;
      ty <= '0;
      bx <= '0;
      by <= '0;
    end else if (step && !last) begin
      if (tx != 3'd7) begin
        tx <= tx + 3'd1;
      end else begin
        tx <= '0;
        if (ty != 3'd7) begin
          ty <= ty + 3'd1;
        end else begin
          ty <= '0;
          if (bx != BX_W'(TILES_X - 1)) begin
            bx <= bx + 1'b1;
          end else begin
            bx <= '0;
            by <= by + 1'b1;
          end
        end
      end
    end
  end

  assign pixel_x = {bx, tx};
  assign pixel_y = {by, ty};
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (clear) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (step && !last) begin
      if (pixel_x == X_WIDTH'(SCREEN_WIDTH - 1)) begin
        pixel_x <= '0;
        pixel_y <= pixel_y + 1'b1;
      end else begin
        pixel_x <= pixel_x + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ray_dispatch.sv
// ray_dispatch: issues one primary-ray request per pixel into the ray core,
// then waits for the core to finish the frame. Tile order: RAY_DISPATCH_TILE_EN.
module ray_dispatch
  import ray_dispatch_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int X_WIDTH       = DEFAULT_X_WIDTH,
  parameter int Y_WIDTH       = DEFAULT_Y_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic               fifo_full,
  input  logic [31:0]        pixel_counter,
  output logic               add_input,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               reset_pixel_counter,
  output logic               busy,
  output logic               frame_done,
  output logic [31:0]        issued_count
);

  localparam logic [31:0] TOTAL = frame_total(SCREEN_WIDTH, SCREEN_HEIGHT);

  RayDispatchState state;
  logic            last;
  logic            scan_clear;

  // Push is combinational so a full FIFO or abort blocks it in the same cycle.
  assign add_input  = (state == ISSUE) && !fifo_full && !abort;
  assign scan_clear = (state == IDLE) && start;

  pixel_scan_counter #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .X_WIDTH      (X_WIDTH),
    .Y_WIDTH      (Y_WIDTH)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (scan_clear),
    .step   (add_input),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .last   (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state               <= IDLE;
      issued_count        <= '0;
      reset_pixel_counter <= 1'b0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
    end else begin
      reset_pixel_counter <= 1'b0;
      frame_done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state               <= CLEAR;
            issued_count        <= '0;
            reset_pixel_counter <= 1'b1;
            busy                <= 1'b1;
          end
        end
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (add_input) begin
            issued_count <= issued_count + 32'd1;
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // >= guards against a core count that overshoots the frame total.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pixel_counter >= TOTAL) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatch.sv
// Directed bench for ray_dispatch: 4x2 raster frame by default, 16x8 tile frame
// when RAY_DISPATCH_TILE_EN is defined.
module tb_ray_dispatch;

`ifdef RAY_DISPATCH_TILE_EN
  localparam int W = 16;
  localparam int H = 8;
`else
  localparam int W = 4;
  localparam int H = 2;
`endif
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        fifo_full;
  logic [31:0] pixel_counter;
  logic        add_input;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        reset_pixel_counter;
  logic        busy;
  logic        frame_done;
  logic [31:0] issued_count;

  int tests = 0;
  int fails = 0;

  // Per-frame observations filled by run_frame.
  int npush, nfd, nrpc, rpc_cyc, rpc_busy, ff_push, fd_busy, fd_issued;
  int ab_add, ab_busy_next, ab_x, ab_y, ab_issued, ns;
  int px[256];
  int py[256];
  int sx[3];
  int sy[3];
  bit timed_out;

  always #5 clk = ~clk;

  ray_dispatch #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .X_WIDTH      (10),
    .Y_WIDTH      (9)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .abort              (abort),
    .fifo_full          (fifo_full),
    .pixel_counter      (pixel_counter),
    .add_input          (add_input),
    .pixel_x            (pixel_x),
    .pixel_y            (pixel_y),
    .reset_pixel_counter(reset_pixel_counter),
    .busy               (busy),
    .frame_done         (frame_done),
    .issued_count       (issued_count)
  );

  function automatic int exp_x(input int i);
`ifdef RAY_DISPATCH_TILE_EN
    return ((i / 64) % (W / 8)) * 8 + (i % 8);
`else
    return i % W;
`endif
  endfunction

  function automatic int exp_y(input int i);
`ifdef RAY_DISPATCH_TILE_EN
    return ((i / 64) / (W / 8)) * 8 + ((i % 64) / 8);
`else
    return i / W;
`endif
  endfunction

  // Runs one frame from a start pulse; optional stall, abort and stray starts.
  task automatic run_frame(input int stall_after, input int abort_after, input bit spam);
    int  drain_wait;
    int  stall_left;
    int  post;
    bit  aborted;
    npush = 0; nfd = 0; nrpc = 0; rpc_cyc = -1; rpc_busy = -1; ff_push = 0;
    fd_busy = -1; fd_issued = -1; ab_add = -1; ab_busy_next = -1; ab_x = -1; ab_y = -1;
    ab_issued = -1; ns = 0; timed_out = 1'b1;
    drain_wait = 0; stall_left = 0; post = 0; aborted = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      start         = (cyc == 0) || (spam && ((npush == 3 && busy) || drain_wait == 1));
      fifo_full     = (stall_left > 0);
      abort         = (abort_after >= 0) && !aborted && (npush == abort_after);
      pixel_counter = (drain_wait >= 3) ? 32'(TOTAL) : 32'd0;
      #1;
      if (reset_pixel_counter) begin
        nrpc++;
        if (rpc_cyc < 0) begin rpc_cyc = cyc; rpc_busy = busy; end
      end
      if (frame_done) begin nfd++; fd_busy = busy; fd_issued = issued_count; end
      if (fifo_full && ns < 3) begin sx[ns] = pixel_x; sy[ns] = pixel_y; ns++; end
      if (add_input) begin
        if (fifo_full) ff_push++;
        if (npush < 256) begin px[npush] = pixel_x; py[npush] = pixel_y; end
        npush++;
      end
      if (abort) begin
        aborted = 1'b1;
        ab_add  = add_input;
      end else if (aborted && ab_busy_next < 0) begin
        ab_busy_next = busy; ab_x = pixel_x; ab_y = pixel_y; ab_issued = issued_count;
      end
      if (busy && !add_input && npush >= TOTAL) drain_wait++;
      if (fifo_full) stall_left--;
      if (add_input && npush == stall_after) stall_left = 3;
      if (nfd > 0 || aborted) post++;
      if (post >= 4) begin timed_out = 1'b0; break; end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; fifo_full = 1'b0; pixel_counter = 32'd0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (add_input !== 1'b0) begin fails++; $display("FAIL reset_add_input got %b want 0", add_input); end
    tests++; if (pixel_x !== 10'd0) begin fails++; $display("FAIL reset_pixel_x got %0d want 0", pixel_x); end
    tests++; if (pixel_y !== 9'd0) begin fails++; $display("FAIL reset_pixel_y got %0d want 0", pixel_y); end
    tests++; if (issued_count !== 32'd0) begin fails++; $display("FAIL reset_issued got %0d want 0", issued_count); end
    tests++; if (reset_pixel_counter !== 1'b0) begin fails++; $display("FAIL reset_rpc got %b want 0", reset_pixel_counter); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0 || add_input !== 1'b0) begin
      fails++; $display("FAIL reset_release_idle got busy=%b add=%b want 0 0", busy, add_input);
    end
  endtask

  task automatic check_order(input string name, input int n);
    int bad;
    bad = -1;
    for (int i = 0; i < n && i < 256; i++)
      if (bad < 0 && (px[i] !== exp_x(i) || py[i] !== exp_y(i))) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s push %0d got (%0d,%0d) want (%0d,%0d)", name, bad, px[bad], py[bad],
               exp_x(bad), exp_y(bad));
    end
  endtask

`ifndef RAY_DISPATCH_TILE_EN
  task automatic test_raster_frame();
    run_frame(-1, -1, 1'b0);
    tests++; if (timed_out) begin fails++; $display("FAIL frame_timeout got timeout want frame_done"); end
    tests++; if (nrpc !== 1 || rpc_cyc !== 1) begin
      fails++; $display("FAIL clear_pulse got count=%0d cyc=%0d want 1 1", nrpc, rpc_cyc);
    end
    tests++; if (rpc_busy !== 1) begin fails++; $display("FAIL clear_busy got %0d want 1", rpc_busy); end
    tests++; if (npush !== 8) begin fails++; $display("FAIL push_count got %0d want 8", npush); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (px[i] !== i % 4 || py[i] !== i / 4) begin
        fails++; $display("FAIL raster_push%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], i % 4, i / 4);
      end
    end
    tests++; if (nfd !== 1) begin fails++; $display("FAIL frame_done_pulses got %0d want 1", nfd); end
    tests++; if (fd_busy !== 0) begin fails++; $display("FAIL done_busy got %0d want 0", fd_busy); end
    tests++; if (fd_issued !== 8) begin fails++; $display("FAIL done_issued got %0d want 8", fd_issued); end
    tests++; if (issued_count !== 32'd8) begin fails++; $display("FAIL issued_hold got %0d want 8", issued_count); end
    tests++; if (pixel_x !== 10'd3 || pixel_y !== 9'd1) begin
      fails++; $display("FAIL coord_hold got (%0d,%0d) want (3,1)", pixel_x, pixel_y);
    end
  endtask

  task automatic test_stall();
    run_frame(2, -1, 1'b0);
    tests++; if (npush !== 8) begin fails++; $display("FAIL stall_push_count got %0d want 8", npush); end
    tests++; if (ff_push !== 0) begin fails++; $display("FAIL stall_push_while_full got %0d want 0", ff_push); end
    tests++; if (ns !== 3) begin fails++; $display("FAIL stall_cycles got %0d want 3", ns); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (sx[i] !== 2 || sy[i] !== 0) begin
        fails++; $display("FAIL stall_hold%0d got (%0d,%0d) want (2,0)", i, sx[i], sy[i]);
      end
    end
    check_order("stall_order", 8);
    tests++; if (nfd !== 1 || issued_count !== 32'd8) begin
      fails++; $display("FAIL stall_done got fd=%0d issued=%0d want 1 8", nfd, issued_count);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(-1, -1, 1'b1);
    tests++; if (npush !== 8) begin fails++; $display("FAIL spam_push_count got %0d want 8", npush); end
    tests++; if (nfd !== 1) begin fails++; $display("FAIL spam_frame_done got %0d want 1", nfd); end
    tests++; if (nrpc !== 1) begin fails++; $display("FAIL spam_clear_pulses got %0d want 1", nrpc); end
    tests++; if (issued_count !== 32'd8) begin fails++; $display("FAIL spam_issued got %0d want 8", issued_count); end
    check_order("spam_order", 8);
  endtask

  task automatic test_abort();
    run_frame(-1, 5, 1'b0);
    tests++; if (ab_add !== 0) begin fails++; $display("FAIL abort_push got %0d want 0", ab_add); end
    tests++; if (ab_busy_next !== 0) begin fails++; $display("FAIL abort_busy got %0d want 0", ab_busy_next); end
    tests++; if (nfd !== 0) begin fails++; $display("FAIL abort_frame_done got %0d want 0", nfd); end
    tests++; if (npush !== 5) begin fails++; $display("FAIL abort_push_count got %0d want 5", npush); end
    tests++; if (ab_issued !== 5 || issued_count !== 32'd5) begin
      fails++; $display("FAIL abort_issued got %0d/%0d want 5", ab_issued, issued_count);
    end
    tests++; if (ab_x !== 1 || ab_y !== 1) begin
      fails++; $display("FAIL abort_coord_hold got (%0d,%0d) want (1,1)", ab_x, ab_y);
    end
    run_frame(-1, -1, 1'b0);
    tests++; if (npush !== 8 || nfd !== 1) begin
      fails++; $display("FAIL after_abort_frame got pushes=%0d fd=%0d want 8 1", npush, nfd);
    end
    check_order("after_abort_order", 8);
  endtask
`else
  task automatic test_tile();
    run_frame(-1, -1, 1'b0);
    tests++; if (npush !== 128) begin fails++; $display("FAIL tile_push_count got %0d want 128", npush); end
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (px[i] !== (i < 8 ? i : 0) || py[i] !== (i < 8 ? 0 : 1)) begin
        fails++; $display("FAIL tile_push%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i],
                          i < 8 ? i : 0, i < 8 ? 0 : 1);
      end
    end
    tests++; if (px[64] !== 8 || py[64] !== 0) begin
      fails++; $display("FAIL tile_push65 got (%0d,%0d) want (8,0)", px[64], py[64]);
    end
    tests++; if (px[127] !== 15 || py[127] !== 7) begin
      fails++; $display("FAIL tile_last got (%0d,%0d) want (15,7)", px[127], py[127]);
    end
    check_order("tile_order", 128);
    tests++; if (nfd !== 1 || issued_count !== 32'd128) begin
      fails++; $display("FAIL tile_done got fd=%0d issued=%0d want 1 128", nfd, issued_count);
    end
  endtask
`endif

  task automatic test_reset_mid_issue();
    int stray;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    tests++; if (add_input !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_issue_active got add=%b busy=%b want 1 1", add_input, busy);
    end
    resetn = 1'b0;
    #1;
    tests++; if (add_input !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || reset_pixel_counter !== 1'b0) begin
      fails++; $display("FAIL async_reset_ctrl got add=%b busy=%b fd=%b rpc=%b want 0 0 0 0",
                        add_input, busy, frame_done, reset_pixel_counter);
    end
    tests++; if (pixel_x !== 10'd0 || pixel_y !== 9'd0 || issued_count !== 32'd0) begin
      fails++; $display("FAIL async_reset_data got x=%0d y=%0d issued=%0d want 0 0 0",
                        pixel_x, pixel_y, issued_count);
    end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (add_input || busy || reset_pixel_counter) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL post_reset_idle got %0d active cycles want 0", stray); end
    run_frame(-1, -1, 1'b0);
    tests++; if (npush !== TOTAL || nfd !== 1) begin
      fails++; $display("FAIL post_reset_frame got pushes=%0d fd=%0d want %0d 1", npush, nfd, TOTAL);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; fifo_full = 1'b0; pixel_counter = 32'd0;
    test_reset();
`ifndef RAY_DISPATCH_TILE_EN
    test_raster_frame();
    test_stall();
    test_start_ignored();
    test_abort();
`else
    test_tile();
`endif
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
